fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage between the program counter register and decode.
- Consumes the current PC value, reads the instruction memory through a request/response handshake, and holds the fetched instruction until decode accepts it.
- Produces the PC's next value and its write enable: sequential +4 advance, or a redirect target from branch/jump resolution.
- One outstanding memory request at a time.

Parameters:
- ADDR_W, 32, width of PC and instruction memory address.
- INST_W, 32, instruction width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  ADDR_W  current PC register value.
- pc_next  output  ADDR_W  value to load into the PC register.
- pc_en  output  1  PC write enable; the PC loads pc_next on the same clk edge.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  ADDR_W  request address.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  INST_W  read data.
- redirect  input  1  control-flow change, one-cycle pulse.
- redirect_target  input  ADDR_W  new PC on redirect.
- id_ready  input  1  decode accepts the instruction this cycle.
- inst_valid  output  1  instruction register holds a valid instruction.
- inst  output  INST_W  fetched instruction.
- inst_pc  output  ADDR_W  address the instruction was fetched from.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=FETCH; kill=0; inst_valid=0; inst=0; inst_pc=0; req_pc=0.
  - While reset is high, imem_req=0 and pc_en=0.
  - Reset takes priority over every other input, including mid-request. A response arriving after reset deasserts is discarded by the memory contract, so the memory must also be reset.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc_in.
  - imem_gnt=1: req_pc<=pc_in, go WAIT. kill<=redirect, so a redirect in the grant cycle kills the accepted request.
  - imem_gnt=0: stay in FETCH; imem_req stays high and imem_addr follows pc_in.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 with kill=0 and redirect=0:
    - inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1.
    - pc_en=1, pc_next=req_pc+PC_STEP (combinational, same cycle).
    - Go HOLD.
  - imem_rvalid=1 with kill=1 or redirect=1: discard the data, kill<=0, go FETCH.
  - imem_rvalid=0 with redirect=1: kill<=1, stay in WAIT.
- HOLD:
  - inst_valid=1; inst and inst_pc are stable; imem_req=0.
  - id_ready=1: inst_valid<=0, go FETCH. The next request issues in the cycle after the handoff.
  - redirect=1: inst_valid<=0, go FETCH; the held instruction is flushed even if id_ready=1 in the same cycle.
- Redirect, any state (reset low):
  - pc_en=1, pc_next=redirect_target.
  - Redirect overrides the sequential pc_next when both occur in one cycle.
- pc_en=0 and pc_next=pc_in in all other cycles.
- Arithmetic:
  - pc_next wraps modulo 2^ADDR_W (0xFFFFFFFC+4=0x00000000).
  - No alignment check; the PC is used as given.
- Throughput: best case one instruction per 3 cycles (FETCH grant, WAIT with rvalid, HOLD accept) with zero-latency memory.
- The memory must not assert imem_rvalid outside WAIT. If it does, the response is ignored.

Test Plan:
- Reset, then pc_in=0x00000000; gnt in cycle 1, rvalid in cycle 2 with rdata=0x00A00093 -> imem_addr=0 in cycle 1; in cycle 2 pc_en=1, pc_next=0x4; in cycle 3 inst_valid=1, inst=0x00A00093, inst_pc=0.
- Hold id_ready=0 for 5 cycles after the previous fetch -> inst, inst_pc and inst_valid stay stable, imem_req=0, pc_en=0. Then id_ready=1 -> inst_valid=0 and imem_req=1 with addr=0x4 the next cycle.
- Redirect pulse in WAIT (target=0x100), rvalid 2 cycles later -> redirect cycle has pc_en=1, pc_next=0x100; the response is discarded (inst_valid stays 0); the next request goes to addr 0x100.
- Redirect and rvalid in the same WAIT cycle (target=0x200) -> pc_next=0x200, no instruction captured, next state FETCH.
- pc_in=0xFFFFFFFC fetch -> pc_next=0x00000000 in the response cycle.
- Reset asserted during WAIT -> next cycle state FETCH, inst_valid=0, kill=0, and imem_req=0 while reset is high.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read at a time, holds the fetched
// instruction for decode and supplies the PC register's next value.
module fetch_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INST_W  = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              id_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic              kill;
    logic [ADDR_W-1:0] req_pc;
    logic              resp_ok;

    // A response is usable only if neither an earlier nor a same-cycle redirect killed it
    assign resp_ok = (state == WAIT) && imem_rvalid && !kill && !redirect;

    // PC update and memory request; redirect wins over the sequential advance
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_in;
        pc_en     = 1'b0;
        pc_next   = pc_in;
        if (!reset) begin
            imem_req = (state == FETCH);
            if (redirect) begin
                pc_en   = 1'b1;
                pc_next = redirect_target;
            end else if (resp_ok) begin
                pc_en   = 1'b1;
                pc_next = req_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            kill       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            req_pc     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_gnt) begin
                        req_pc <= pc_in;
                        kill   <= redirect;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (resp_ok) begin
                            inst       <= imem_rdata;
                            inst_pc    <= req_pc;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // Redirect flushes the held instruction even if decode takes it
                    if (redirect || id_ready) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_next;
    logic          pc_en;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          id_ready;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .INST_W(IW), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_target(redirect_target), .id_ready(id_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: an optional outstanding read, a 0/1-deep queue of held
    // instructions, and the last captured instruction (registers keep it).
    typedef struct packed {
        logic [IW-1:0] ins;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        held[$];
    bit            out_busy = 1'b0;
    bit            out_dead = 1'b0;
    logic [AW-1:0] out_pc   = '0;
    logic [IW-1:0] last_inst = '0;
    logic [AW-1:0] last_pc   = '0;
    logic          exp_en;
    logic [AW-1:0] exp_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic bit issuing();
        return !out_busy && (held.size() == 0);
    endfunction

    task automatic drive(input bit r, input bit g, input bit v, input logic [31:0] d,
                         input bit rd, input logic [31:0] tg, input bit ir);
        reset = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        redirect = rd; redirect_target = tg; id_ready = ir;
    endtask

    // Compare every output against the model mid-cycle.
    task automatic settle();
        #1;
        exp_en   = 1'b0;
        exp_next = pc_in;
        if (!reset) begin
            if (redirect) begin
                exp_en   = 1'b1;
                exp_next = redirect_target;
            end else if (out_busy && imem_rvalid && !out_dead) begin
                exp_en   = 1'b1;
                exp_next = out_pc + 32'd4;
            end
        end
        chk("imem_req", 32'(imem_req), 32'(!reset && issuing()));
        if (!reset && issuing()) chk("imem_addr", imem_addr, pc_in);
        chk("pc_en", 32'(pc_en), 32'(exp_en));
        chk("pc_next", pc_next, exp_next);
        chk("inst_valid", 32'(inst_valid), 32'(held.size() != 0));
        chk("inst", inst, last_inst);
        chk("inst_pc", inst_pc, last_pc);
    endtask

    // Advance one clock and apply the same cycle's inputs to the model and PC.
    task automatic tick();
        bit iss;
        iss = issuing();
        @(posedge clk);
        #1;
        if (reset) begin
            held.delete();
            out_busy  = 1'b0;
            out_dead  = 1'b0;
            last_inst = '0;
            last_pc   = '0;
        end else if (iss) begin
            if (imem_gnt) begin
                out_busy = 1'b1;
                out_dead = redirect;
                out_pc   = pc_in;
            end
        end else if (out_busy) begin
            if (imem_rvalid) begin
                if (!out_dead && !redirect) begin
                    held.push_back('{imem_rdata, out_pc});
                    last_inst = imem_rdata;
                    last_pc   = out_pc;
                end
                out_busy = 1'b0;
                out_dead = 1'b0;
            end else if (redirect) begin
                out_dead = 1'b1;
            end
        end else if (redirect || id_ready) begin
            held.delete();
        end
        if (exp_en) pc_in = exp_next;
    endtask

    task automatic step(input bit r, input bit g, input bit v, input logic [31:0] d,
                        input bit rd, input logic [31:0] tg, input bit ir);
        drive(r, g, v, d, rd, tg, ir);
        settle();
        tick();
    endtask

    initial begin
        pc_in = 32'h0;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);

        // Basic fetch from 0
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("tp1_addr", imem_addr, 32'h0);
        tick();
        drive(0, 0, 1, 32'h00A00093, 0, 0, 0); settle();
        chk("tp1_pc_en", 32'(pc_en), 32'd1);
        chk("tp1_pc_next", pc_next, 32'h4);
        tick();

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0); settle();
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, 32'h00A00093);
            chk("hold_pc", inst_pc, 32'h0);
            chk("hold_req", 32'(imem_req), 32'd0);
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("handoff_valid", 32'(inst_valid), 32'd0);
        chk("handoff_req", 32'(imem_req), 32'd1);
        chk("handoff_addr", imem_addr, 32'h4);
        tick();

        // Redirect while waiting; late response is discarded
        drive(0, 0, 0, 0, 1, 32'h100, 0); settle();
        chk("rdw_pc_en", 32'(pc_en), 32'd1);
        chk("rdw_pc_next", pc_next, 32'h100);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'hDEADBEEF, 0, 0, 1); settle();
        chk("rdw_resp_pc_en", 32'(pc_en), 32'd0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("rdw_valid", 32'(inst_valid), 32'd0);
        chk("rdw_addr", imem_addr, 32'h100);
        tick();

        // Redirect coincident with the response
        drive(0, 0, 1, 32'h11111111, 1, 32'h200, 0); settle();
        chk("rdv_pc_next", pc_next, 32'h200);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); settle();
        chk("rdv_valid", 32'(inst_valid), 32'd0);
        chk("rdv_req", 32'(imem_req), 32'd1);
        chk("rdv_addr", imem_addr, 32'h200);
        tick();

        // Wraparound of the sequential PC
        pc_in = 32'hFFFF_FFFC;
        step(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h12345678, 0, 0, 0); settle();
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1); settle();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();

        // Reset in WAIT with a pending kill; the next fetch must not be killed
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h300, 0);
        drive(1, 0, 0, 0, 0, 0, 0); settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        tick();
        drive(1, 1, 1, 32'h5555_5555, 1, 32'h400, 1); settle();
        chk("rst_prio_req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0); settle();
        chk("rst_after_req", 32'(imem_req), 32'd1);
        chk("rst_after_valid", 32'(inst_valid), 32'd0);
        tick();
        drive(0, 0, 1, 32'hCAFEF00D, 0, 0, 0); settle();
        chk("rst_kill_clear", 32'(pc_en), 32'd1);
        chk("rst_kill_next", pc_next, 32'h304);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); settle();
        chk("rst_capture", inst, 32'hCAFEF00D);
        tick();

        // Random traffic, including stray responses outside WAIT
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 4,
                 $urandom,
                 $urandom_range(0, 11) == 0,
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
